// File: rtl/spi_bram_bridge_pkg.sv
// Shared definitions for the SPI-to-BRAM command bridge: opcodes, FSM state
// encoding and the bytes-per-word derivation.
package spi_bram_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_SET   = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_LEN_HI  = 3'd3,
    ST_LEN_LO  = 3'd4,
    ST_WRITE   = 3'd5,
    ST_READ    = 3'd6
  } state_t;

  function automatic int calc_bpw(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/spi_bram_bridge_if.sv
// SPI byte stream and BRAM port bundle; master is the bridge side, slave is
// the SPI slave / BRAM side.
interface spi_bram_bridge_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
);
  logic              spi_cycle_done;
  logic [7:0]        spi_byte_in;
  logic [7:0]        spi_byte_out;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_data_in;
  logic [DATA_W-1:0] bram_data_out;

  modport master (
    input  spi_cycle_done, spi_byte_in, bram_data_out,
    output spi_byte_out, bram_addr, bram_we, bram_data_in
  );

  modport slave (
    output spi_cycle_done, spi_byte_in, bram_data_out,
    input  spi_byte_out, bram_addr, bram_we, bram_data_in
  );
endinterface

// File: rtl/spi_bram_bridge_byte_word_packer.sv
// Shared shift register that assembles BRAM words from SPI bytes (WRITE) and
// serialises fetched words back into bytes, MSB first (READ).
module byte_word_packer
  import spi_bram_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_in,
  input  logic [7:0]        byte_in,
  input  logic              advance,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  output logic [DATA_W-1:0] word_next,
  output logic [7:0]        byte_next,
  output logic              last
);

  localparam int BPW   = calc_bpw(DATA_W);
  localparam int IDX_W = 2;

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;

  assign last      = (idx_q == IDX_W'(BPW - 1));
  assign word_next = word_d;
  assign byte_next = word_d[DATA_W-1 -: 8];

  // Next word/index: a load replaces any same-cycle advance of the stale word
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load) begin
      word_d = word_in;
      idx_d  = '0;
    end else if (shift_in || advance) begin
      word_d = shift_in ? DATA_W'({word_q, byte_in}) : (word_q << 8);
      idx_d  = last ? '0 : idx_q + 2'd1;
    end else begin
      word_d = word_q;
      idx_d  = idx_q;
    end
  end

  // Word and byte-index state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/spi_bram_bridge.sv
// Command-driven bridge between a byte-wide SPI slave and a synchronous BRAM:
// framed WRITE/READ/SET with word packing, address auto-increment and wrap.
module spi_bram_bridge
  import spi_bram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_bram_bridge_if.master    bus,
  output logic [2:0]           state,
  output logic                 xfer_done,
  output logic                 addr_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [16:0]       DEPTH_V   = 17'(DEPTH);

  state_t            st_r;
  logic [7:0]        op_r;
  logic [7:0]        addr_hi_r;
  logic [7:0]        len_hi_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       count_r;
  logic              issue_r;
  logic              cap_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;
  logic [7:0]        byte_out_r;
  logic              xfer_r;
  logic              err_r;

  logic [ADDR_W-1:0] next_addr;
  logic [15:0]       addr_full;
  logic [15:0]       len_full;
  logic              pk_clr;
  logic              pk_shift;
  logic              pk_adv;
  logic              pk_load;
  logic [DATA_W-1:0] pk_word;
  logic [7:0]        pk_byte;
  logic              pk_last;

  assign next_addr = (addr_r == LAST_ADDR) ? '0 : addr_r + ADDR_W'(1);
  assign addr_full = {addr_hi_r, bus.spi_byte_in};
  assign len_full  = {len_hi_r, bus.spi_byte_in};

  assign pk_clr   = (st_r == ST_LEN_LO) && bus.spi_cycle_done;
  assign pk_shift = (st_r == ST_WRITE)  && bus.spi_cycle_done;
  assign pk_adv   = (st_r == ST_READ)   && bus.spi_cycle_done;
  assign pk_load  = (st_r == ST_READ)   && cap_r;

  byte_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .shift_in  (pk_shift),
    .byte_in   (bus.spi_byte_in),
    .advance   (pk_adv),
    .load      (pk_load),
    .word_in   (bus.bram_data_out),
    .word_next (pk_word),
    .byte_next (pk_byte),
    .last      (pk_last)
  );

  // Command FSM, BRAM strobes and SPI output byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r       <= ST_IDLE;
      op_r       <= 8'h00;
      addr_hi_r  <= 8'h00;
      len_hi_r   <= 8'h00;
      addr_r     <= '0;
      count_r    <= 16'h0000;
      issue_r    <= 1'b0;
      cap_r      <= 1'b0;
      we_r       <= 1'b0;
      wdata_r    <= '0;
      byte_out_r <= 8'h00;
      xfer_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      xfer_r  <= 1'b0;
      we_r    <= 1'b0;
      issue_r <= 1'b0;
      cap_r   <= issue_r;

      // The cycle after a write strobe retires the word; the final word leaves WRITE here
      if (we_r) begin
        addr_r  <= next_addr;
        count_r <= count_r - 16'd1;
        if (count_r == 16'd1) begin
          st_r <= ST_IDLE;
        end else begin
          st_r <= st_r;
        end
      end else begin
        addr_r <= addr_r;
      end

      if (pk_load) begin
        byte_out_r <= pk_byte;
      end else begin
        byte_out_r <= byte_out_r;
      end

      case (st_r)
        ST_IDLE: begin
          if (bus.spi_cycle_done) begin
            case (bus.spi_byte_in)
              OP_WRITE, OP_READ, OP_SET: begin
                op_r <= bus.spi_byte_in;
                st_r <= ST_ADDR_HI;
              end
              default: st_r <= ST_IDLE;
            endcase
          end else begin
            st_r <= ST_IDLE;
          end
        end
        ST_ADDR_HI: begin
          if (bus.spi_cycle_done) begin
            addr_hi_r <= bus.spi_byte_in;
            st_r      <= ST_ADDR_LO;
          end else begin
            st_r <= ST_ADDR_HI;
          end
        end
        ST_ADDR_LO: begin
          if (bus.spi_cycle_done) begin
            if ({1'b0, addr_full} >= DEPTH_V) begin
              addr_r <= '0;
              err_r  <= 1'b1;
            end else begin
              addr_r <= addr_full[ADDR_W-1:0];
              if (op_r == OP_SET) begin
                err_r <= 1'b0;
              end else begin
                err_r <= err_r;
              end
            end
            st_r <= ST_LEN_HI;
          end else begin
            st_r <= ST_ADDR_LO;
          end
        end
        ST_LEN_HI: begin
          if (bus.spi_cycle_done) begin
            len_hi_r <= bus.spi_byte_in;
            st_r     <= ST_LEN_LO;
          end else begin
            st_r <= ST_LEN_HI;
          end
        end
        ST_LEN_LO: begin
          if (bus.spi_cycle_done) begin
            count_r <= len_full;
            if (op_r == OP_SET || len_full == 16'd0) begin
              st_r   <= ST_IDLE;
              xfer_r <= 1'b1;
            end else if (op_r == OP_WRITE) begin
              st_r <= ST_WRITE;
            end else begin
              st_r    <= ST_READ;
              issue_r <= 1'b1;
            end
          end else begin
            st_r <= ST_LEN_LO;
          end
        end
        ST_WRITE: begin
          if (bus.spi_cycle_done && pk_last) begin
            we_r    <= 1'b1;
            wdata_r <= pk_word;
            xfer_r  <= (count_r == 16'd1);
          end else begin
            wdata_r <= wdata_r;
          end
        end
        ST_READ: begin
          if (bus.spi_cycle_done) begin
            if (!pk_last) begin
              byte_out_r <= pk_byte;
            end else if (count_r == 16'd1) begin
              st_r       <= ST_IDLE;
              xfer_r     <= 1'b1;
              byte_out_r <= 8'h00;
            end else begin
              addr_r  <= next_addr;
              count_r <= count_r - 16'd1;
              issue_r <= 1'b1;
            end
          end else begin
            st_r <= ST_READ;
          end
        end
        default: st_r <= ST_IDLE;
      endcase
    end
  end

  assign state            = st_r;
  assign xfer_done        = xfer_r;
  assign addr_err         = err_r;
  assign bus.spi_byte_out = byte_out_r;
  assign bus.bram_addr    = addr_r;
  assign bus.bram_we      = we_r;
  assign bus.bram_data_in = wdata_r;

endmodule

// File: tb/tb_spi_bram_bridge.sv
// Directed bench: an 8-bit/32768-word bridge and a 16-bit/19200-word bridge,
// each with a synchronous BRAM model and strobe monitors.
module tb_spi_bram_bridge;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic [2:0] state_a, state_b;
  logic xd_a, xd_b, ae_a, ae_b;

  int checks = 0;
  int failures = 0;

  spi_bram_bridge_if #(.DATA_W(8),  .ADDR_W(15)) ia();
  spi_bram_bridge_if #(.DATA_W(16), .ADDR_W(15)) ib();

  spi_bram_bridge #(.DATA_W(8), .ADDR_W(15), .DEPTH(32768)) u_a (
    .clk(clk), .rst(rst_a), .bus(ia.master),
    .state(state_a), .xfer_done(xd_a), .addr_err(ae_a)
  );

  spi_bram_bridge #(.DATA_W(16), .ADDR_W(15), .DEPTH(19200)) u_b (
    .clk(clk), .rst(rst_b), .bus(ib.master),
    .state(state_b), .xfer_done(xd_b), .addr_err(ae_b)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem_a [0:32767];
  logic [15:0] mem_b [0:32767];
  int we_cnt_a = 0, we_cnt_b = 0, xd_cnt_a = 0, xd_cnt_b = 0, bad_we = 0;
  logic [14:0] we_addr_a [0:15];
  logic [14:0] we_addr_b [0:15];

  // BRAM models and strobe monitors
  always @(posedge clk) begin
    ia.bram_data_out <= mem_a[ia.bram_addr];
    ib.bram_data_out <= mem_b[ib.bram_addr];
    if (ia.bram_we) begin
      mem_a[ia.bram_addr] <= ia.bram_data_in;
      we_addr_a[we_cnt_a % 16] <= ia.bram_addr;
      we_cnt_a <= we_cnt_a + 1;
      if (state_a != 3'd5) bad_we <= bad_we + 1;
    end
    if (ib.bram_we) begin
      mem_b[ib.bram_addr] <= ib.bram_data_in;
      we_addr_b[we_cnt_b % 16] <= ib.bram_addr;
      we_cnt_b <= we_cnt_b + 1;
      if (state_b != 3'd5) bad_we <= bad_we + 1;
    end
    if (xd_a) xd_cnt_a <= xd_cnt_a + 1;
    if (xd_b) xd_cnt_b <= xd_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int dut, input logic [7:0] b);
    @(negedge clk);
    if (dut == 0) begin ia.spi_byte_in = b; ia.spi_cycle_done = 1'b1; end
    else          begin ib.spi_byte_in = b; ib.spi_cycle_done = 1'b1; end
    @(negedge clk);
    ia.spi_cycle_done = 1'b0;
    ib.spi_cycle_done = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic slot(input int dut, output logic [7:0] got);
    got = (dut == 0) ? ia.spi_byte_out : ib.spi_byte_out;
    send(dut, 8'h00);
  endtask

  int we0, xd0;
  logic [7:0] got;

  initial begin
    ia.spi_cycle_done = 1'b0; ia.spi_byte_in = 8'h00;
    ib.spi_cycle_done = 1'b0; ib.spi_byte_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    check("rst_state",   32'(state_a),          32'd0);
    check("rst_byteout", 32'(ia.spi_byte_out),  32'h00);
    check("rst_addr",    32'(ia.bram_addr),     32'h0);
    check("rst_we",      32'(ia.bram_we),       32'd0);
    check("rst_wdata",   32'(ia.bram_data_in),  32'h0);
    check("rst_xfer",    32'(xd_a),             32'd0);
    check("rst_err",     32'(ae_a),             32'd0);

    // 8-bit WRITE 0x0010 len 3
    we0 = we_cnt_a; xd0 = xd_cnt_a;
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h10); send(0, 8'h00); send(0, 8'h03);
    check("w8_state", 32'(state_a), 32'd5);
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    check("w8_we_cnt", 32'(we_cnt_a - we0), 32'd3);
    check("w8_addr0",  32'(we_addr_a[we0 % 16]),       32'h10);
    check("w8_addr1",  32'(we_addr_a[(we0 + 1) % 16]), 32'h11);
    check("w8_addr2",  32'(we_addr_a[(we0 + 2) % 16]), 32'h12);
    check("w8_mem10",  32'(mem_a[16'h10]), 32'h11);
    check("w8_mem11",  32'(mem_a[16'h11]), 32'h22);
    check("w8_mem12",  32'(mem_a[16'h12]), 32'h33);
    check("w8_xfer",   32'(xd_cnt_a - xd0), 32'd1);
    check("w8_idle",   32'(state_a), 32'd0);

    // 8-bit READ back the same range
    xd0 = xd_cnt_a;
    send(0, 8'h02); send(0, 8'h00); send(0, 8'h10); send(0, 8'h00); send(0, 8'h03);
    slot(0, got); check("r8_slot0", 32'(got), 32'h11);
    slot(0, got); check("r8_slot1", 32'(got), 32'h22);
    slot(0, got); check("r8_slot2", 32'(got), 32'h33);
    check("r8_xfer",    32'(xd_cnt_a - xd0), 32'd1);
    check("r8_idle",    32'(state_a), 32'd0);
    check("r8_byteout", 32'(ia.spi_byte_out), 32'h00);

    // SET out of range, then valid SET
    send(0, 8'h03); send(0, 8'h90); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    check("set_err",  32'(ae_a), 32'd1);
    check("set_addr", 32'(ia.bram_addr), 32'h0);
    send(0, 8'h03); send(0, 8'h00); send(0, 8'h05); send(0, 8'h00); send(0, 8'h00);
    check("set_clr",   32'(ae_a), 32'd0);
    check("set_addr5", 32'(ia.bram_addr), 32'h5);

    // Unknown opcode followed by four bytes
    we0 = we_cnt_a; xd0 = xd_cnt_a;
    send(0, 8'h7F);
    check("bad_op_state0", 32'(state_a), 32'd0);
    send(0, 8'h10); send(0, 8'h20); send(0, 8'h30); send(0, 8'h40);
    check("bad_op_state", 32'(state_a), 32'd0);
    check("bad_op_we",    32'(we_cnt_a - we0), 32'd0);
    check("bad_op_xfer",  32'(xd_cnt_a - xd0), 32'd0);
    check("bad_op_addr",  32'(ia.bram_addr), 32'h5);

    // 16-bit WRITE addr 0 len 2
    we0 = we_cnt_b;
    send(1, 8'h01); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00); send(1, 8'h02);
    send(1, 8'hAB); send(1, 8'hCD); send(1, 8'h12); send(1, 8'h34);
    check("w16_we_cnt", 32'(we_cnt_b - we0), 32'd2);
    check("w16_mem0",   32'(mem_b[0]), 32'hABCD);
    check("w16_mem1",   32'(mem_b[1]), 32'h1234);

    // 16-bit WRITE across the DEPTH boundary
    we0 = we_cnt_b;
    send(1, 8'h01); send(1, 8'h4A); send(1, 8'hFF); send(1, 8'h00); send(1, 8'h02);
    send(1, 8'h01); send(1, 8'h02); send(1, 8'h03); send(1, 8'h04);
    check("wrap_we_cnt", 32'(we_cnt_b - we0), 32'd2);
    check("wrap_addr0",  32'(we_addr_b[we0 % 16]),       32'd19199);
    check("wrap_addr1",  32'(we_addr_b[(we0 + 1) % 16]), 32'd0);
    check("wrap_mem_hi", 32'(mem_b[19199]), 32'h0102);
    check("wrap_mem_lo", 32'(mem_b[0]),     32'h0304);
    check("wrap_next",   32'(ib.bram_addr), 32'd1);

    // 16-bit READ across the boundary
    xd0 = xd_cnt_b;
    send(1, 8'h02); send(1, 8'h4A); send(1, 8'hFF); send(1, 8'h00); send(1, 8'h02);
    slot(1, got); check("r16_slot0", 32'(got), 32'h01);
    slot(1, got); check("r16_slot1", 32'(got), 32'h02);
    slot(1, got); check("r16_slot2", 32'(got), 32'h03);
    slot(1, got); check("r16_slot3", 32'(got), 32'h04);
    check("r16_xfer", 32'(xd_cnt_b - xd0), 32'd1);
    check("r16_idle", 32'(state_b), 32'd0);

    // LEN=0 WRITE
    we0 = we_cnt_b; xd0 = xd_cnt_b;
    send(1, 8'h01); send(1, 8'h00); send(1, 8'h05); send(1, 8'h00); send(1, 8'h00);
    check("len0_we",    32'(we_cnt_b - we0), 32'd0);
    check("len0_xfer",  32'(xd_cnt_b - xd0), 32'd1);
    check("len0_state", 32'(state_b), 32'd0);

    // Reset after the first byte of a 16-bit word
    we0 = we_cnt_b;
    send(1, 8'h01); send(1, 8'h00); send(1, 8'h07); send(1, 8'h00); send(1, 8'h01);
    send(1, 8'hAA);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_we",      32'(we_cnt_b - we0), 32'd0);
    check("abort_state",   32'(state_b), 32'd0);
    check("abort_byteout", 32'(ib.spi_byte_out), 32'h00);
    check("abort_addr",    32'(ib.bram_addr), 32'h0);
    check("abort_we_out",  32'(ib.bram_we), 32'd0);
    check("abort_wdata",   32'(ib.bram_data_in), 32'h0);
    check("abort_xfer",    32'(xd_b), 32'd0);
    check("abort_err",     32'(ae_b), 32'd0);

    check("we_outside_write", 32'(bad_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
